// File: rtl/mips_control_muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_control_muldiv_sequencer_pkg
// Brief  : Shared types and constants for the HI/LO multiply/divide
//          sequencer: operation codes, operation type, FSM state codes and
//          an operation-class helper.
// Rev    : 1.0  initial release
// ============================================================================
package mips_control_muldiv_sequencer_pkg;

    // Operation code carried from decode/control into the HI/LO unit.
    localparam int OP_W = 3;
    typedef logic [OP_W-1:0] muldiv_op_t;

    localparam muldiv_op_t c_op_none  = 3'd0;
    localparam muldiv_op_t c_op_mult  = 3'd1;
    localparam muldiv_op_t c_op_multu = 3'd2;
    localparam muldiv_op_t c_op_div   = 3'd3;
    localparam muldiv_op_t c_op_divu  = 3'd4;
    localparam muldiv_op_t c_op_mthi  = 3'd5;
    localparam muldiv_op_t c_op_mtlo  = 3'd6;
    // Code 7 is reserved and behaves exactly like c_op_none.

    // Sequencer FSM states.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;

    // True for the four operations that occupy the iterative datapath.
    function automatic logic op_is_muldiv(input muldiv_op_t code);
        return (code == c_op_mult) || (code == c_op_multu) ||
               (code == c_op_div)  || (code == c_op_divu);
    endfunction

    // True for any operation that wants the HI/LO resource this cycle.
    function automatic logic op_is_active(input muldiv_op_t code);
        return (code != c_op_none) && (code != 3'd7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_control_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module : mips_control_muldiv_step
// Brief  : One radix-2 iteration on the {acc, q} register pair (purely
//          combinational).
//          Multiply : if q[0], acc += m; then shift the 2W-bit {carry,acc,q}
//                     right by one.
//          Divide   : shift {acc,q} left by one, trial-subtract m from the
//                     upper half, keep the difference and set the quotient
//                     bit when it does not go negative (restoring divide).
// Ports  : is_div   in   1      select divide iteration (else multiply)
//          acc      in   WIDTH  upper half (partial product / remainder)
//          q        in   WIDTH  lower half (multiplier / dividend->quotient)
//          m        in   WIDTH  multiplicand / divisor
//          acc_next out  WIDTH  upper half after this iteration
//          q_next   out  WIDTH  lower half after this iteration
// Rev    : 1.0  initial release
// ============================================================================
module mips_control_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: keep the carry so the right shift does not lose it.
    assign w_sum = {1'b0, acc} + {1'b0, m};
    assign w_add = q[0] ? w_sum : {1'b0, acc};

    // Divide: the shifted partial remainder is one bit wider than m. Since
    // the remainder always stays below m, a successful trial subtraction
    // fits back into WIDTH bits, so a WIDTH-bit difference is exact.
    assign w_shl  = {acc, q[WIDTH-1]};
    assign w_ge   = (w_shl >= {1'b0, m});
    assign w_diff = w_shl[WIDTH-1:0] - m;

    always_comb begin
        acc_next = {w_add[WIDTH:1]};
        q_next   = {w_add[0], q[WIDTH-1:1]};
        if (is_div) begin
            if (w_ge) begin
                acc_next = w_diff;
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = w_shl[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_control_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mips_control_muldiv_sequencer
// Brief  : Multi-cycle controller for the MIPS HI/LO resource. Accepts one
//          MULT/MULTU/DIV/DIVU at a time, iterates WIDTH cycles on a shared
//          add-shift / restore-subtract step, applies sign correction and
//          writes HI/LO. MTHI/MTLO write directly while idle. Produces the
//          pipeline stall for MFHI/MFLO readers and for new producers.
// Ports  : clock   in   1      clock, all state changes on posedge
//          reset   in   1      synchronous active-high reset
//          op      in   3      operation code (see package)
//          rs      in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//          rt      in   WIDTH  multiplier / divisor
//          readHi  in   1      EX holds MFHI this cycle
//          readLo  in   1      EX holds MFLO this cycle
//          flush   in   1      squash the in-flight operation
//          busy    out  1      sequencer not idle
//          stall   out  1      hold EX and earlier stages this cycle
//          done    out  1      HI/LO take a mul/div result at the next edge
//          hi      out  WIDTH  HI register
//          lo      out  WIDTH  LO register
// Rev    : 1.0  initial release
// ============================================================================
module mips_control_muldiv_sequencer
    import mips_control_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             readHi,
    input  logic             readLo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_count_init = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_is_div;
    logic             r_neg_res;   // product / quotient must be negated
    logic             r_neg_rem;   // remainder must be negated
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // ------------------------------------------------------------------
    // Operation decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    muldiv_op_t       w_op;
    logic             w_signed;
    logic             w_div_op;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic             w_div_zero;
    logic             w_start;

    assign w_op       = op;
    assign w_signed   = (w_op == c_op_mult) || (w_op == c_op_div);
    assign w_div_op   = (w_op == c_op_div)  || (w_op == c_op_divu);
    assign w_rs_neg   = w_signed & rs[WIDTH-1];
    assign w_rt_neg   = w_signed & rt[WIDTH-1];
    // The magnitude of the most negative value is itself, which is the
    // correct unsigned magnitude.
    assign w_rs_mag   = w_rs_neg ? -rs : rs;
    assign w_rt_mag   = w_rt_neg ? -rt : rt;
    assign w_div_zero = w_div_op && (rt == '0);
    assign w_start    = (r_state == c_st_idle) && !flush && op_is_muldiv(w_op);

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;

    mips_control_muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .q        (r_q),
        .m        (r_m),
        .acc_next (w_acc_next),
        .q_next   (w_q_next)
    );

    // ------------------------------------------------------------------
    // Sign correction for the FIX cycle
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -r_q : r_q;
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;

    // ------------------------------------------------------------------
    // FSM, operand latches and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_is_div <= w_div_op;
                        r_count  <= c_count_init;
                        if (w_div_zero) begin
                            // Divide by zero: preload the FIX result
                            // (HI = raw dividend, LO = all ones) with sign
                            // correction disabled, and skip RUN.
                            r_acc     <= rs;
                            r_q       <= '1;
                            r_m       <= '0;
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                            r_state   <= c_st_fix;
                        end else begin
                            r_acc     <= '0;
                            r_q       <= w_div_op ? w_rs_mag : w_rt_mag;
                            r_m       <= w_div_op ? w_rt_mag : w_rs_mag;
                            r_neg_res <= w_rs_neg ^ w_rt_neg;
                            r_neg_rem <= w_rs_neg;
                            r_state   <= c_st_run;
                        end
                    end else if (!flush) begin
                        if (w_op == c_op_mthi) begin
                            r_hi <= rs;
                        end
                        if (w_op == c_op_mtlo) begin
                            r_lo <= rs;
                        end
                    end
                end

                c_st_run: begin
                    if (flush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_q     <= w_q_next;
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == '0) begin
                            r_state <= c_st_fix;
                        end
                    end
                end

                c_st_fix: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = (r_state != c_st_idle);
    // A squashed instruction must never hold the pipeline.
    assign stall = busy & ~flush & (readHi | readLo | op_is_active(w_op));
    assign done  = (r_state == c_st_fix) & ~flush;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_control_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_control_muldiv_sequencer
// Brief  : Self-checking bench for the HI/LO multiply/divide sequencer.
//          A table of directed mul/div vectors with hand-computed HI/LO and
//          busy-cycle counts, plus hand-written sequences for MTHI/MTLO,
//          stall on reads, flush, held ops and reset mid-operation.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_control_muldiv_sequencer;

    localparam int W = 32;

    localparam logic [2:0] c_none  = 3'd0;
    localparam logic [2:0] c_mult  = 3'd1;
    localparam logic [2:0] c_multu = 3'd2;
    localparam logic [2:0] c_div   = 3'd3;
    localparam logic [2:0] c_divu  = 3'd4;
    localparam logic [2:0] c_mthi  = 3'd5;
    localparam logic [2:0] c_mtlo  = 3'd6;

    logic         clock  = 1'b0;
    logic         reset  = 1'b1;
    logic [2:0]   op     = 3'd0;
    logic [W-1:0] rs     = '0;
    logic [W-1:0] rt     = '0;
    logic         readHi = 1'b0;
    logic         readLo = 1'b0;
    logic         flush  = 1'b0;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    mips_control_muldiv_sequencer #(
        .WIDTH  (W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .readHi (readHi),
        .readLo (readLo),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           busy_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an op for exactly one edge; returns #1 after that edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        op = o;
        rs = a;
        rt = b;
        @(posedge clock);
        #1;
        op = c_none;
    endtask

    // Counts busy cycles up to and including the done cycle.
    task automatic wait_done(output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_done: no done within 100 cycles, got busy=%0d expected done", busy);
        end
    endtask

    initial begin : main
        int   cyc;
        logic ok;
        int   stall_n;
        logic got_done;

        vecs[0]  = '{c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1]  = '{c_mult,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[2]  = '{c_div,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{c_divu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
        vecs[4]  = '{c_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[5]  = '{c_div,   32'd17,        32'd5,         32'd2,         32'd3,         33};
        vecs[6]  = '{c_divu,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};
        vecs[7]  = '{c_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[8]  = '{c_div,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[9]  = '{c_div,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
        vecs[10] = '{c_multu, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         33};
        vecs[11] = '{c_multu, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         33};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        readHi = 1'b1;
        #1;
        chk("idle read no stall", 32'(stall), 32'd0);
        readHi = 1'b0;

        // ---------------- MTHI / MTLO back to back ----------------
        @(negedge clock);
        op = c_mthi;
        rs = 32'h0000_AAAA;
        #1;
        chk("mthi stall", 32'(stall), 32'd0);
        @(negedge clock);
        op = c_mtlo;
        rs = 32'h0000_5555;
        chk("mthi hi", hi, 32'h0000_AAAA);
        chk("mthi busy", 32'(busy), 32'd0);
        @(negedge clock);
        op = c_none;
        chk("mtlo lo", lo, 32'h0000_5555);
        chk("mtlo hi kept", hi, 32'h0000_AAAA);
        chk("mtlo busy", 32'(busy), 32'd0);

        // ---------------- table of mul/div vectors ----------------
        for (int v = 0; v < 12; v++) begin
            start_op(vecs[v].op, vecs[v].rs, vecs[v].rt);
            wait_done(cyc, ok);
            if (ok) begin
                chk($sformatf("v%0d busy cycles", v), 32'(cyc), 32'(vecs[v].busy_cyc));
                @(posedge clock);
                #1;
                chk($sformatf("v%0d hi", v), hi, vecs[v].hi);
                chk($sformatf("v%0d lo", v), lo, vecs[v].lo);
                chk($sformatf("v%0d idle after", v), 32'(busy), 32'd0);
                chk($sformatf("v%0d done one pulse", v), 32'(done), 32'd0);
            end
        end

        // ---------------- DIV 17/5 with readLo held ----------------
        start_op(c_div, 32'd17, 32'd5);
        readLo   = 1'b1;
        stall_n  = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            @(negedge clock);
            if (stall) stall_n++;
            if (done) got_done = 1'b1;
        end
        chk("t4 done seen", 32'(got_done), 32'd1);
        chk("t4 stall cycles", 32'(stall_n), 32'd33);
        @(negedge clock);
        chk("t4 stall released", 32'(stall), 32'd0);
        chk("t4 lo", lo, 32'd3);
        chk("t4 hi", hi, 32'd2);
        readLo = 1'b0;

        // ---------------- flush in RUN ----------------
        @(negedge clock);
        op = c_mthi;
        rs = 32'h0000_1234;
        @(negedge clock);
        op = c_mtlo;
        rs = 32'h0000_5678;
        @(negedge clock);
        op = c_none;
        start_op(c_mult, 32'd3, 32'd5);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush  = 1'b1;
        readHi = 1'b1;
        #1;
        chk("flush busy before", 32'(busy), 32'd1);
        chk("flush forces stall 0", 32'(stall), 32'd0);
        chk("flush no done", 32'(done), 32'd0);
        @(posedge clock);
        #1;
        flush  = 1'b0;
        readHi = 1'b0;
        chk("flush to idle", 32'(busy), 32'd0);
        chk("flush hi kept", hi, 32'h0000_1234);
        chk("flush lo kept", lo, 32'h0000_5678);

        // flush beats a same-cycle op in IDLE
        @(negedge clock);
        op    = c_mult;
        rs    = 32'd1;
        rt    = 32'd1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        op    = c_none;
        flush = 1'b0;
        chk("idle flush blocks op", 32'(busy), 32'd0);

        // a new op is accepted right after
        start_op(c_multu, 32'd2, 32'd3);
        chk("accept after flush", 32'(busy), 32'd1);
        wait_done(cyc, ok);
        @(posedge clock);
        #1;
        chk("post-flush hi", hi, 32'd0);
        chk("post-flush lo", lo, 32'd6);

        // ---------------- flush in FIX (divide by zero path) ----------------
        start_op(c_divu, 32'd5, 32'd0);
        flush = 1'b1;
        #1;
        chk("fix flush no done", 32'(done), 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("fix flush idle", 32'(busy), 32'd0);
        chk("fix flush hi kept", hi, 32'd0);
        chk("fix flush lo kept", lo, 32'd6);

        // ---------------- op held while busy ----------------
        start_op(c_multu, 32'd4, 32'd5);
        @(negedge clock);
        op = c_mthi;
        rs = 32'h0000_DEAD;
        #1;
        chk("held op stalls", 32'(stall), 32'd1);
        for (int i = 0; i < 100 && stall; i++) begin
            @(posedge clock);
            #1;
        end
        chk("held op released", 32'(stall), 32'd0);
        chk("held op hi before", hi, 32'd0);
        chk("held op lo", lo, 32'd20);
        @(posedge clock);
        #1;
        op = c_none;
        chk("held mthi written", hi, 32'h0000_DEAD);

        // ---------------- reset mid-RUN ----------------
        start_op(c_mult, 32'd7, 32'd9);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrun reset hi", hi, 32'd0);
        chk("midrun reset lo", lo, 32'd0);
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset done", 32'(done), 32'd0);
        chk("midrun reset stall", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
